// File: rtl/viti_pkg.sv
// Shared definitions for the TDL calibration scheduler: FSM encoding,
// default evaluation window length and the reset value of exp_ones.
package viti_pkg;

    localparam int unsigned WIN_LEN_DEF = 32;
    localparam logic [2:0] EXP_ONES_RST = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SETTLE   = 3'd1,
        ST_TRIG     = 3'd2,
        ST_WAIT_RES = 3'd3,
        ST_EVAL     = 3'd4,
        ST_STEP     = 3'd5,
        ST_DONE     = 3'd6
    } state_t;

endpackage

// File: rtl/viti_calib_timer.sv
// Loadable down-counter shared by the tap settle wait and the result timeout.
module viti_calib_timer #(
    parameter int unsigned W = 13
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         en,
    input  logic [W-1:0] load_val,
    output logic         zero_c
);

    logic [W-1:0] count;

    // Load wins over decrement; the count parks at zero.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/viti_calib_sched.sv
// Calibration scheduler: sweeps the IODELAY tap, triggers captures and locks on
// the first window showing an edge. Optional lock hysteresis: CALIB_HYST_EN.
module viti_calib_sched #(
    parameter int unsigned TAP_W       = 5,
    parameter int unsigned TAP_MAX     = 31,
    parameter int unsigned WIN_LEN     = viti_pkg::WIN_LEN_DEF,
    parameter int unsigned SETTLE_CYC  = 16,
    parameter int unsigned TIMEOUT_CYC = 4096
`ifdef CALIB_HYST_EN
    ,
    parameter int unsigned HYST_RUNS   = 2
`endif
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    output logic             cap_trig,
    input  logic             cap_busy,
    input  logic             res_valid,
    input  logic [7:0]       res_mismatch,
    input  logic [2:0]       res_ones,
    output logic [2:0]       exp_ones,
    output logic             dly_ce,
    output logic             dly_inc,
    output logic [TAP_W-1:0] dly_tap,
    output logic             busy,
    output logic             calib_done,
    output logic             calib_locked,
    output logic             calib_fail
);

    import viti_pkg::*;

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
`ifdef CALIB_HYST_EN
    localparam int unsigned HIT_W = $clog2(HYST_RUNS + 1);
`endif

    state_t           state, state_d;
    logic [TAP_W-1:0] tap_d;
    logic [2:0]       exp_d, ones_q, ones_d;
    logic [7:0]       m_q, m_d;
    logic             adopt_used, adopt_d;
    logic             busy_d, done_d, locked_d, fail_d, trig_d, ce_d;
    logic             t_load, t_en, t_zero;
    logic [CNT_W-1:0] t_val;
    logic             edge_run, adopt_ok;
`ifdef CALIB_HYST_EN
    logic [HIT_W-1:0] hit_cnt, hit_d;
`endif

    viti_calib_timer #(.W(CNT_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (t_load),
        .en       (t_en),
        .load_val (t_val),
        .zero_c   (t_zero)
    );

    // A partial mismatch marks an edge; a full-scale window is a polarity
    // hint adopted once per tap, and anything above full scale is no-edge.
    assign edge_run = (m_q != 8'd0) && (m_q < 8'(WIN_LEN));
    assign adopt_ok = (m_q == 8'(WIN_LEN)) && !adopt_used;

    always_comb begin
        state_d  = state;
        tap_d    = dly_tap;
        exp_d    = exp_ones;
        adopt_d  = adopt_used;
        busy_d   = busy;
        done_d   = calib_done;
        locked_d = calib_locked;
        fail_d   = calib_fail;
        trig_d   = 1'b0;
        ce_d     = 1'b0;
        m_d      = m_q;
        ones_d   = ones_q;
        t_load   = 1'b0;
        t_en     = 1'b0;
        t_val    = '0;
`ifdef CALIB_HYST_EN
        hit_d    = hit_cnt;
`endif
        case (state)
            ST_IDLE: begin
                if (start) begin
                    done_d   = 1'b0;
                    locked_d = 1'b0;
                    fail_d   = 1'b0;
                    tap_d    = '0;
                    adopt_d  = 1'b0;
                    busy_d   = 1'b1;
                    t_load   = 1'b1;
                    t_val    = CNT_W'(SETTLE_CYC);
`ifdef CALIB_HYST_EN
                    hit_d    = '0;
`endif
                    state_d  = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                t_en = 1'b1;
                if (t_zero) state_d = ST_TRIG;
            end
            ST_TRIG: begin
                if (!cap_busy) begin
                    trig_d  = 1'b1;
                    t_load  = 1'b1;
                    t_val   = CNT_W'(TIMEOUT_CYC);
                    state_d = ST_WAIT_RES;
                end
            end
            ST_WAIT_RES: begin
                t_en = 1'b1;
                if (res_valid) begin
                    m_d     = res_mismatch;
                    ones_d  = res_ones;
                    state_d = ST_EVAL;
                end else if (t_zero) begin
                    fail_d  = 1'b1;
                    state_d = ST_DONE;
                end
            end
            ST_EVAL: begin
                if (edge_run) begin
`ifdef CALIB_HYST_EN
                    if (32'(hit_cnt) + 32'd1 >= HYST_RUNS) begin
                        locked_d = 1'b1;
                        state_d  = ST_DONE;
                    end else begin
                        hit_d   = hit_cnt + HIT_W'(1);
                        state_d = ST_TRIG;
                    end
`else
                    locked_d = 1'b1;
                    state_d  = ST_DONE;
`endif
                end else begin
`ifdef CALIB_HYST_EN
                    hit_d = '0;
`endif
                    if (adopt_ok) begin
                        exp_d   = ones_q;
                        adopt_d = 1'b1;
                        state_d = ST_TRIG;
                    end else begin
                        state_d = ST_STEP;
                    end
                end
            end
            ST_STEP: begin
                if (dly_tap == TAP_W'(TAP_MAX)) begin
                    fail_d  = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    ce_d    = 1'b1;
                    tap_d   = dly_tap + TAP_W'(1);
                    adopt_d = 1'b0;
                    t_load  = 1'b1;
                    t_val   = CNT_W'(SETTLE_CYC);
                    state_d = ST_SETTLE;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= ST_IDLE;
            dly_tap      <= '0;
            exp_ones     <= EXP_ONES_RST;
            adopt_used   <= 1'b0;
            busy         <= 1'b0;
            calib_done   <= 1'b0;
            calib_locked <= 1'b0;
            calib_fail   <= 1'b0;
            cap_trig     <= 1'b0;
            dly_ce       <= 1'b0;
            dly_inc      <= 1'b0;
            m_q          <= '0;
            ones_q       <= '0;
        end else begin
            state        <= state_d;
            dly_tap      <= tap_d;
            exp_ones     <= exp_d;
            adopt_used   <= adopt_d;
            busy         <= busy_d;
            calib_done   <= done_d;
            calib_locked <= locked_d;
            calib_fail   <= fail_d;
            cap_trig     <= trig_d;
            dly_ce       <= ce_d;
            dly_inc      <= ce_d;
            m_q          <= m_d;
            ones_q       <= ones_d;
        end
    end

`ifdef CALIB_HYST_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) hit_cnt <= '0;
        else       hit_cnt <= hit_d;
    end
`endif

endmodule

// File: tb/tb_viti_calib_sched.sv
// Scoreboard bench for viti_calib_sched: a capture model answers each trigger
// from a response queue; sweep outcomes are predicted per run and checked at done.
module tb_viti_calib_sched;

`ifdef CALIB_HYST_EN
    localparam int XTRA = 1;
`else
    localparam int XTRA = 0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       cap_trig;
    logic       cap_busy;
    logic       res_valid;
    logic [7:0] res_mismatch;
    logic [2:0] res_ones;
    logic [2:0] exp_ones;
    logic       dly_ce;
    logic       dly_inc;
    logic [4:0] dly_tap;
    logic       busy;
    logic       calib_done;
    logic       calib_locked;
    logic       calib_fail;

    viti_calib_sched dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .cap_trig     (cap_trig),
        .cap_busy     (cap_busy),
        .res_valid    (res_valid),
        .res_mismatch (res_mismatch),
        .res_ones     (res_ones),
        .exp_ones     (exp_ones),
        .dly_ce       (dly_ce),
        .dly_inc      (dly_inc),
        .dly_tap      (dly_tap),
        .busy         (busy),
        .calib_done   (calib_done),
        .calib_locked (calib_locked),
        .calib_fail   (calib_fail)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       locked;
        logic       fail;
        logic [4:0] tap;
        logic [2:0] exp;
        int         trig;
        int         ce;
    } exp_t;

    exp_t sb[$];
    int   resp_m[$];
    int   resp_ones[$];
    int   n_checks = 0;
    int   n_fail = 0;
    int   n_trig, n_ce, first_trig;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, want);
        end
    endtask

    task automatic push_resp(input int m, input int ones);
        resp_m.push_back(m);
        resp_ones.push_back(ones);
    endtask

    // An edge run is repeated so that hysteresis builds see enough hits.
    task automatic push_edge(input int m, input int ones);
        for (int i = 0; i <= XTRA; i++) push_resp(m, ones);
    endtask

    task automatic push_exp(input logic lk, input logic fl, input int tap,
                            input int ex, input int trig, input int ce);
        exp_t e;
        e.locked = lk; e.fail = fl; e.tap = 5'(tap); e.exp = 3'(ex);
        e.trig = trig; e.ce = ce;
        sb.push_back(e);
    endtask

    // Run one sweep; abort_ce > 0 stops it 3 cycles after that many tap steps.
    task automatic run_sweep(input string name, input int budget, input int abort_ce,
                             input bit chk_lat);
        int  pend = 0;
        int  ce_at = -1;
        bit  done_seen = 0;
        bit  aborted = 0;
        logic [7:0] cur_m = '0;
        logic [2:0] cur_ones = '0;
        exp_t e;
        n_trig = 0; n_ce = 0; first_trig = -1;
        start = 1'b1;
        for (int cyc = 0; cyc < budget && !done_seen && !aborted; cyc++) begin
            @(negedge clk);
            start = 1'b0;
            res_valid = 1'b0;
            if (cyc == 0) check({name, "_busy_after_start"}, 32'(busy), 1);
            if (cyc == 5) begin
                res_valid = 1'b1;
                res_mismatch = 8'd20;
                res_ones = 3'd1;
            end
            if (cyc == 40 && busy) start = 1'b1;
            if (pend > 0) begin
                pend--;
                if (pend == 0) begin
                    res_valid = 1'b1;
                    res_mismatch = cur_m;
                    res_ones = cur_ones;
                    cap_busy = 1'b0;
                end
            end
            if (cap_trig) begin
                n_trig++;
                if (first_trig < 0) first_trig = cyc;
                cap_busy = 1'b1;
                if (resp_m.size() > 0) begin
                    cur_m = 8'(resp_m.pop_front());
                    cur_ones = 3'(resp_ones.pop_front());
                    pend = 3;
                end
            end
            if (dly_ce) begin
                n_ce++;
                ce_at = cyc;
                check({name, "_dly_inc"}, 32'(dly_inc), 1);
            end
            if (abort_ce > 0 && n_ce == abort_ce && cyc == ce_at + 3) aborted = 1;
            if (calib_done) done_seen = 1;
        end
        if (aborted) return;
        res_valid = 1'b0;
        cap_busy = 1'b0;
        if (!done_seen) begin
            check({name, "_done_within_budget"}, 0, 1);
        end else if (sb.size() == 0) begin
            check({name, "_scoreboard_entry"}, 0, 1);
        end else begin
            e = sb.pop_front();
            check({name, "_locked"}, 32'(calib_locked), 32'(e.locked));
            check({name, "_fail"}, 32'(calib_fail), 32'(e.fail));
            check({name, "_tap"}, 32'(dly_tap), 32'(e.tap));
            check({name, "_exp_ones"}, 32'(exp_ones), 32'(e.exp));
            check({name, "_triggers"}, 32'(n_trig), 32'(e.trig));
            check({name, "_tap_steps"}, 32'(n_ce), 32'(e.ce));
            check({name, "_busy_at_done"}, 32'(busy), 0);
            if (chk_lat) check({name, "_start_to_trig"}, 32'(first_trig), 32'(16 + 2));
        end
        resp_m.delete();
        resp_ones.delete();
    endtask

    task automatic check_reset_vals(input string name);
        check({name, "_busy"}, 32'(busy), 0);
        check({name, "_done"}, 32'(calib_done), 0);
        check({name, "_locked"}, 32'(calib_locked), 0);
        check({name, "_fail"}, 32'(calib_fail), 0);
        check({name, "_tap"}, 32'(dly_tap), 0);
        check({name, "_exp_ones"}, 32'(exp_ones), 4);
        check({name, "_trig_ce"}, 32'({cap_trig, dly_ce, dly_inc}), 0);
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b0;
        cap_busy = 1'b0;
        res_valid = 1'b0;
        res_mismatch = '0;
        res_ones = '0;
        repeat (3) @(negedge clk);
        check_reset_vals("por");
        reset = 1'b0;
        @(negedge clk);

        // T1: edge on the very first run.
        push_edge(5, 4);
        push_exp(1, 0, 0, 4, 1 + XTRA, 0);
        run_sweep("t1", 400, 0, 1);

        // T2: no edge on taps 0..6 (tap 6 over full scale), edge at tap 7.
        for (int t = 0; t < 6; t++) push_resp(0, 4);
        push_resp(40, 4);
        push_edge(12, 4);
        push_exp(1, 0, 7, 4, 8 + XTRA, 7);
        run_sweep("t2", 1500, 0, 0);

        // T3: full-scale window adopts res_ones and re-triggers on the same tap.
        push_resp(32, 3);
        push_resp(0, 3);
        push_edge(10, 3);
        push_exp(1, 0, 1, 3, 3 + XTRA, 1);
        run_sweep("t3", 800, 0, 0);

        // T4: nothing on any tap; sweep ends at the last tap.
        for (int t = 0; t < 32; t++) push_resp(0, 3);
        push_exp(0, 1, 31, 3, 32, 31);
        run_sweep("t4", 3000, 0, 0);

        // T5: no result after the trigger.
        push_exp(0, 1, 0, 3, 1, 0);
        run_sweep("t5_timeout", 5000, 0, 0);

        // Reset while settling on tap 2.
        for (int t = 0; t < 3; t++) push_resp(0, 3);
        run_sweep("t5_abort", 1000, 2, 0);
        check("t5_abort_tap_before_reset", 32'(dly_tap), 2);
        check("t5_abort_busy_before_reset", 32'(busy), 1);
        reset = 1'b1;
        #1;
        check_reset_vals("mid_reset");
        resp_m.delete();
        resp_ones.delete();
        cap_busy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        push_edge(31, 6);
        push_exp(1, 0, 0, 4, 1 + XTRA, 0);
        run_sweep("t5_after_reset", 400, 0, 1);

        // Second full-scale window on a tap counts as no-edge.
        push_resp(32, 2);
        push_resp(32, 5);
        push_edge(9, 2);
        push_exp(1, 0, 1, 2, 3 + XTRA, 1);
        run_sweep("adopt_once", 800, 0, 0);

        // T6: edge, no-edge, edge, edge.
        push_resp(5, 2);
        push_resp(0, 2);
        push_resp(5, 2);
        push_resp(5, 2);
`ifdef CALIB_HYST_EN
        push_exp(1, 0, 1, 2, 4, 1);
`else
        push_exp(1, 0, 0, 2, 1, 0);
`endif
        run_sweep("t6", 800, 0, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
